// File: rtl/z_mips_pkg.sv
// MIPS opcode, funct and field-position constants
// shared by the decode stage and its register file.
package z_mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_JR  = 6'h08;

   localparam int OP_LSB = 26;
   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;
   localparam int SH_LSB = 6;

   localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/z_regfile.sv
// 2-read / 1-write register file, r0 hardwired to zero,
// reads bypass a same-cycle write.
module z_regfile
   import z_mips_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int DW    = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] ra_addr,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] ra_data,
   output logic [DW-1:0] rb_data,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data
);

   logic [DW-1:0] regs [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en && wr_addr != '0) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      ra_data = regs[ra_addr];
      if (ra_addr == '0)
         ra_data = '0;
      else if (wr_en && wr_addr == ra_addr)
         ra_data = wr_data;
   end

   always_comb begin
      rb_data = regs[rb_addr];
      if (rb_addr == '0)
         rb_data = '0;
      else if (wr_en && wr_addr == rb_addr)
         rb_data = wr_data;
   end

endmodule

// File: rtl/z_decode.sv
// Decode / operand-fetch stage: register file, RAW scoreboard,
// and the registered operand bundle presented to z_ALU.
module z_decode
   import z_mips_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ins_valid_in,
   input  logic [31:0]   ins_in,
   output logic          ins_ready_out,
   input  logic          wb_en_in,
   input  logic [4:0]    wb_addr_in,
   input  logic [DW-1:0] wb_data_in,
   output logic          ex_valid_out,
   input  logic          ex_ready_in,
   output logic [DW-1:0] a_out,
   output logic [DW-1:0] b_out,
   output logic [4:0]    shamt_out,
   output logic [31:0]   ins_out
);

   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, sh, dest;
   logic [15:0] imm;
   logic        is_r, use_rs, use_rt, hazard, space, accept;
   logic [DW-1:0] ra_data, rb_data, b_dec;
   logic [NREGS-1:0] busy, clr, set;

   assign op  = ins_in[OP_LSB +: 6];
   assign rs  = ins_in[RS_LSB +: 5];
   assign rt  = ins_in[RT_LSB +: 5];
   assign rd  = ins_in[RD_LSB +: 5];
   assign sh  = ins_in[SH_LSB +: 5];
   assign fn  = ins_in[5:0];
   assign imm = ins_in[15:0];
   assign is_r = (op == OP_RTYPE);

   z_regfile #(.NREGS(NREGS), .DW(DW)) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .ra_addr (rs),
      .rb_addr (rt),
      .ra_data (ra_data),
      .rb_data (rb_data),
      .wr_en   (wb_en_in),
      .wr_addr (wb_addr_in),
      .wr_data (wb_data_in)
   );

   always_comb begin
      dest  = '0;
      b_dec = {{(DW-16){imm[15]}}, imm};
      unique case (1'b1)
         is_r: begin
            b_dec = rb_data;
            dest  = (fn == FN_JR) ? 5'd0 : rd;
         end
         (op >= OP_ANDI && op <= OP_XORI): begin
            b_dec = {{(DW-16){1'b0}}, imm};
            dest  = rt;
         end
         (op == OP_LUI): begin
            b_dec = {imm, 16'h0000};
            dest  = rt;
         end
         (op >= OP_ADDI && op < OP_ANDI),
         (op >= OP_LB && op <= OP_LHU): dest = rt;
         (op == OP_JAL): dest = REG_RA;
         default: ;
      endcase
   end

   assign use_rs = !(op == OP_J || op == OP_JAL ||
                     (is_r && (fn == FN_SLL || fn == FN_SRL ||
                               fn == FN_SRA)));
   assign use_rt = is_r || op == OP_BEQ || op == OP_BNE ||
                   (op >= OP_SB && op <= OP_SW);

   always_comb begin
      clr = '0;
      set = '0;
      if (wb_en_in) clr[wb_addr_in] = 1'b1;
      if (accept) set[dest] = 1'b1;
      set[0] = 1'b0;
   end

   // A writeback landing this cycle releases its register immediately.
   assign hazard = (use_rs && busy[rs] && !clr[rs]) ||
                   (use_rt && busy[rt] && !clr[rt]);
   assign space  = !ex_valid_out || ex_ready_in;
   assign ins_ready_out = rst_n && space && !hazard;
   assign accept = ins_valid_in && ins_ready_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= (busy & ~clr) | set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_out <= 1'b0;
         a_out        <= '0;
         b_out        <= '0;
         shamt_out    <= '0;
         ins_out      <= '0;
      end else begin
         if (space) ex_valid_out <= accept;
         if (accept) begin
            a_out     <= ra_data;
            b_out     <= b_dec;
            shamt_out <= sh;
            ins_out   <= ins_in;
         end
      end
   end

endmodule

// File: tb/tb_z_decode.sv
// Bench for z_decode: directed vectors, an immediate-decode table
// and random traffic against a behavioural model of the stage.
module tb_z_decode;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ins_valid_in;
   logic [31:0] ins_in;
   logic        ins_ready_out;
   logic        wb_en_in;
   logic [4:0]  wb_addr_in;
   logic [31:0] wb_data_in;
   logic        ex_valid_out;
   logic        ex_ready_in;
   logic [31:0] a_out, b_out, ins_out;
   logic [4:0]  shamt_out;

   always #5 clk = ~clk;

   z_decode dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ins_valid_in  (ins_valid_in),
      .ins_in        (ins_in),
      .ins_ready_out (ins_ready_out),
      .wb_en_in      (wb_en_in),
      .wb_addr_in    (wb_addr_in),
      .wb_data_in    (wb_data_in),
      .ex_valid_out  (ex_valid_out),
      .ex_ready_in   (ex_ready_in),
      .a_out         (a_out),
      .b_out         (b_out),
      .shamt_out     (shamt_out),
      .ins_out       (ins_out)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference state
   logic [31:0] m_reg [32];
   bit          m_busy [32];
   bit          m_valid;
   logic [31:0] m_a, m_b, m_ins;
   logic [4:0]  m_sh;
   bit          seen_ready;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = 0;
         m_busy[i] = 0;
      end
      m_valid = 0;
      m_a = 0; m_b = 0; m_ins = 0; m_sh = 0;
   endfunction

   function automatic int m_dest(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      if (op == 0) return (ins[5:0] == 6'h08) ? 0 : int'(ins[15:11]);
      if ((op >= 8 && op <= 15) || (op >= 32 && op <= 37))
         return int'(ins[20:16]);
      if (op == 3) return 31;
      return 0;
   endfunction

   function automatic bit m_use_rs(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      int fn = int'(ins[5:0]);
      return !(op == 2 || op == 3 ||
               (op == 0 && (fn == 0 || fn == 2 || fn == 3)));
   endfunction

   function automatic bit m_use_rt(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      return op == 0 || op == 4 || op == 5 || (op >= 40 && op <= 43);
   endfunction

   function automatic logic [31:0] m_bimm(input logic [31:0] ins);
      int op = int'(ins[31:26]);
      longint unsigned imm = ins[15:0];
      if (op >= 12 && op <= 14) return 32'(imm);
      if (op == 15) return 32'(imm * 65536);
      return (imm >= 32768) ? 32'(imm + 64'hFFFF0000) : 32'(imm);
   endfunction

   function automatic logic [31:0] busy_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_busy[i];
      return v;
   endfunction

   // One clock: drive at posedge+1, check ready mid-cycle,
   // check registered outputs at next posedge+1.
   task automatic cycle(input bit v, input logic [31:0] ins,
                        input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input bit er);
      int rs, rt, dst;
      bit haz, rdy, acc;
      logic [31:0] na, nb;
      ins_valid_in = v;
      ins_in       = ins;
      wb_en_in     = we;
      wb_addr_in   = wa;
      wb_data_in   = wd;
      ex_ready_in  = er;
      #2;
      rs  = int'(ins[25:21]);
      rt  = int'(ins[20:16]);
      dst = m_dest(ins);
      haz = (m_use_rs(ins) && m_busy[rs] && !(we && int'(wa) == rs)) ||
            (m_use_rt(ins) && m_busy[rt] && !(we && int'(wa) == rt));
      rdy = (!m_valid || er) && !haz;
      seen_ready = ins_ready_out;
      chk("ins_ready_out", {31'b0, ins_ready_out}, {31'b0, rdy});
      acc = v && rdy;
      na = (rs == 0) ? 0 : (we && int'(wa) == rs) ? wd : m_reg[rs];
      if (ins[31:26] == 6'h00)
         nb = (rt == 0) ? 0 : (we && int'(wa) == rt) ? wd : m_reg[rt];
      else
         nb = m_bimm(ins);
      @(posedge clk);
      if (we && wa != 0) m_reg[wa] = wd;
      if (we) m_busy[wa] = 0;
      if (acc && dst != 0) m_busy[dst] = 1;
      if (acc) begin
         m_valid = 1;
         m_a = na; m_b = nb; m_sh = ins[10:6]; m_ins = ins;
      end else if (er) begin
         m_valid = 0;
      end
      #1;
      chk("ex_valid_out", {31'b0, ex_valid_out}, {31'b0, m_valid});
      chk("a_out", a_out, m_a);
      chk("b_out", b_out, m_b);
      chk("shamt_out", {27'b0, shamt_out}, {27'b0, m_sh});
      chk("ins_out", ins_out, m_ins);
      chk("busy", dut.busy, busy_vec());
   endtask

   typedef struct {
      logic [31:0] ins;
      logic [31:0] b;
   } vec_t;

   vec_t tbl [8];

   int ops [19] = '{0, 0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 14, 15,
                    32, 35, 37, 40, 43, 63};
   int fns [8]  = '{0, 2, 3, 8, 32, 33, 35, 42};

   initial begin
      tbl[0] = '{32'h34028001, 32'h00008001};
      tbl[1] = '{32'h20028001, 32'hFFFF8001};
      tbl[2] = '{32'h3C021234, 32'h12340000};
      tbl[3] = '{32'h3003FFFF, 32'h0000FFFF};
      tbl[4] = '{32'h3803F0F0, 32'h0000F0F0};
      tbl[5] = '{32'h2804FFFF, 32'hFFFFFFFF};
      tbl[6] = '{32'hAC058000, 32'hFFFF8000};
      tbl[7] = '{32'hFC007FFF, 32'h00007FFF};

      rst_n = 0;
      ins_valid_in = 0; ins_in = 0;
      wb_en_in = 0; wb_addr_in = 0; wb_data_in = 0;
      ex_ready_in = 1;
      model_reset();
      #13;
      chk("rst_ready", {31'b0, ins_ready_out}, 32'd0);
      chk("rst_valid", {31'b0, ex_valid_out}, 32'd0);
      chk("rst_a", a_out, 32'd0);
      chk("rst_ins", ins_out, 32'd0);
      @(posedge clk); #1;
      rst_n = 1;

      // subu r31,r31,r0 after writing r31
      cycle(0, 0, 1, 31, 32'h14D5A6BB, 1);
      cycle(1, 32'h03E0F823, 0, 0, 0, 1);
      chk("subu_valid", {31'b0, ex_valid_out}, 32'd1);
      chk("subu_a", a_out, 32'h14D5A6BB);
      chk("subu_b", b_out, 32'd0);
      chk("subu_ins", ins_out, 32'h03E0F823);
      chk("subu_busy31", {31'b0, dut.busy[31]}, 32'd1);

      // sll r31,r31,5 stalls until r31 is written back
      cycle(1, 32'h001FF940, 0, 0, 0, 1);
      chk("sll_stall0", {31'b0, seen_ready}, 32'd0);
      cycle(1, 32'h001FF940, 0, 0, 0, 1);
      chk("sll_stall1", {31'b0, seen_ready}, 32'd0);
      cycle(1, 32'h001FF940, 1, 31, 32'h5D2E8274, 1);
      chk("sll_ready", {31'b0, seen_ready}, 32'd1);
      chk("sll_b_bypass", b_out, 32'h5D2E8274);
      chk("sll_shamt", {27'b0, shamt_out}, 32'd5);
      chk("sll_busy31", {31'b0, dut.busy[31]}, 32'd1);
      cycle(0, 0, 1, 31, 32'h5D2E8274, 1);

      for (int i = 0; i < 8; i++) begin
         cycle(1, tbl[i].ins, 0, 0, 0, 1);
         chk($sformatf("tbl%0d_b", i), b_out, tbl[i].b);
         chk($sformatf("tbl%0d_ins", i), ins_out, tbl[i].ins);
      end

      // r0 writes are dropped
      cycle(0, 0, 1, 0, 32'hFFFFFFFF, 1);
      cycle(1, 32'h00003021, 0, 0, 0, 1);
      chk("r0_a", a_out, 32'd0);
      chk("r0_b", b_out, 32'd0);
      chk("r0_busy0", {31'b0, dut.busy[0]}, 32'd0);

      // 3-cycle downstream stall
      for (int i = 0; i < 3; i++) begin
         cycle(1, 32'h34070001, 0, 0, 0, 0);
         chk("stall_ready", {31'b0, seen_ready}, 32'd0);
         chk("stall_ins", ins_out, 32'h00003021);
      end
      cycle(1, 32'h34070001, 0, 0, 0, 1);
      chk("release_ins", ins_out, 32'h34070001);
      chk("release_b", b_out, 32'h00000001);

      // async reset in the middle of a stall
      cycle(1, 32'h34080002, 0, 0, 0, 0);
      #3;
      rst_n = 0;
      #1;
      chk("mrst_valid", {31'b0, ex_valid_out}, 32'd0);
      chk("mrst_a", a_out, 32'd0);
      chk("mrst_b", b_out, 32'd0);
      chk("mrst_sh", {27'b0, shamt_out}, 32'd0);
      chk("mrst_ins", ins_out, 32'd0);
      chk("mrst_busy", dut.busy, 32'd0);
      chk("mrst_ready", {31'b0, ins_ready_out}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1;
      model_reset();

      for (int n = 0; n < 400; n++) begin
         logic [31:0] ins;
         ins = {6'(ops[$urandom_range(0, 18)]),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom),
                6'(fns[$urandom_range(0, 7)])};
         if (ins[31:26] != 6'h00 && $urandom_range(0, 1) == 1)
            ins[15] = 1'b1;
         cycle(($urandom % 4) != 0, ins,
               ($urandom % 3) == 0, 5'($urandom_range(0, 7)),
               $urandom, ($urandom % 4) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
